// File: rtl/dmem_responder.sv
// Purpose: single-port 32-bit data-memory responder with byte/half/word access and error reporting.
// Latency: response is valid LATENCY cycles after the request is accepted; one access in flight at a time.
// Backpressure: req_ready only in IDLE; the response is held stable in RESP until resp_ready is seen.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h01000000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;
  logic        w_exec;

  // Captured request fields, held for the whole access.
  logic [31:0] r_addr;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;

  // Response registers.
  logic [31:0] r_rdata;
  logic        r_err;

  // Storage is never reset so contents survive a reset pulse.
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]   w_offset;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_err;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wword;
  logic [31:0]   w_rword;
  logic [31:0]   w_rshift;
  logic [31:0]   w_rdata_fmt;

  assign req_ready  = (r_state == IDLE) && !rst;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, hold in RESP until taken.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid && req_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_exec      = !rst;
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Address decode, error detection and lane steering for the captured request.
  always_comb begin
    w_offset = r_addr - BASE_ADDR;
    w_idx    = w_offset[AW+1:2];
    w_lane   = r_addr[1:0];
    w_err    = 1'b0;
    if (r_size == 2'd3)                           w_err = 1'b1;
    if ((r_size == 2'd1) && r_addr[0])            w_err = 1'b1;
    if ((r_size == 2'd2) && (r_addr[1:0] != 2'd0)) w_err = 1'b1;
    if ((r_addr < BASE_ADDR) || ({1'b0, w_offset} >= SPAN)) w_err = 1'b1;

    case (r_size)
      2'd0: begin
        w_wmask = 4'b0001 << w_lane;
        w_wword = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_wmask = 4'b0011 << w_lane;
        w_wword = {2{r_wdata[15:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wword = r_wdata;
      end
    endcase

    w_rword  = r_mem[w_idx];
    w_rshift = w_rword >> {w_lane, 3'b000};
    case (r_size)
      2'd0:    w_rdata_fmt = {24'd0, w_rshift[7:0]};
      2'd1:    w_rdata_fmt = {16'd0, w_rshift[15:0]};
      default: w_rdata_fmt = w_rword;
    endcase
  end

  // Storage write: only a legal write executing outside reset touches memory.
  always_ff @(posedge clk) begin
    if (w_exec && r_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  // Request capture and response data; errors and writes return zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_size  <= req_size;
        r_wdata <= req_wdata;
      end
      if (w_exec) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? 32'd0 : w_rdata_fmt;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (LATENCY=2, 256 words at 0x01000000).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_dmem_responder;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transaction with resp_ready held high; returns the response.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_addr = a; req_we = we; req_size = sz; req_wdata = wd;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL timeout addr=%h: resp_valid never rose, want 1", a);
    end
    rd = resp_rdata; er = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", resp_err); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word_rw;
    logic [31:0] rd; logic er;
    do_req(32'h01000004, 1'b1, 2'd2, 32'hDEADBEEF, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL wr_word_resp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    do_req(32'h01000005, 1'b0, 2'd0, 32'd0, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'h000000BE) begin errors++; $display("FAIL rd_byte5: got err=%b rdata=%h want 0/000000be", er, rd); end
    do_req(32'h01000006, 1'b0, 2'd1, 32'd0, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'h0000DEAD) begin errors++; $display("FAIL rd_half6: got err=%b rdata=%h want 0/0000dead", er, rd); end
    do_req(32'h01000004, 1'b0, 2'd0, 32'd0, rd, er);
    checks++; if (rd !== 32'h000000EF) begin errors++; $display("FAIL rd_byte4: got %h want 000000ef", rd); end
    do_req(32'h01000007, 1'b1, 2'd0, 32'hFFFFFF5A, rd, er);
    do_req(32'h01000004, 1'b1, 2'd1, 32'hFFFF1234, rd, er);
    do_req(32'h01000004, 1'b0, 2'd2, 32'd0, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'h5AAD1234) begin errors++; $display("FAIL partial_writes: got %h want 5aad1234", rd); end
  endtask

  task automatic test_latency;
    req_addr = 32'h01000004; req_we = 1'b0; req_size = 2'd2; req_wdata = 32'd0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL lat_edge_n: got valid=%b ready=%b want 0/0", resp_valid, req_ready); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL lat_edge_n1: got valid=%b ready=%b want 0/0", resp_valid, req_ready); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL lat_edge_n2: got valid=%b ready=%b want 1/0", resp_valid, req_ready); end
    checks++; if (resp_rdata !== 32'h5AAD1234) begin errors++; $display("FAIL lat_rdata: got %h want 5aad1234", resp_rdata); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int n;
    do_req(32'h01000000, 1'b1, 2'd2, 32'h12345678, rd, er);
    req_addr = 32'h01000000; req_we = 1'b0; req_size = 2'd2;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    // A write offered while busy must be ignored, including across the handshake edge.
    req_we = 1'b1; req_wdata = 32'hFFFFFFFF;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678 || resp_err !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got valid=%b rdata=%h err=%b want 1/12345678/0", i, resp_valid, resp_rdata, resp_err);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL after_hs: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
    req_valid = 1'b0;
    do_req(32'h01000000, 1'b0, 2'd2, 32'd0, rd, er);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL busy_ignored: got %h want 12345678", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er;
    do_req(32'h01000001, 1'b1, 2'd1, 32'h0000AAAA, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_half_wr: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(32'h00FFFFFC, 1'b0, 2'd2, 32'd0, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL below_base: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(32'h00FFFFFF, 1'b0, 2'd0, 32'd0, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL below_base_byte: got err=%b want 1", er); end
    do_req(32'h01000400, 1'b1, 2'd2, 32'h0BADF00D, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL above_top: got err=%b want 1", er); end
    do_req(32'h01000000, 1'b0, 2'd3, 32'd0, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL size3: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(32'h01000002, 1'b1, 2'd2, 32'hFFFFFFFF, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_word: got err=%b want 1", er); end
    do_req(32'h010003FC, 1'b1, 2'd2, 32'hCAFEF00D, rd, er);
    do_req(32'h010003FF, 1'b0, 2'd0, 32'd0, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'h000000CA) begin errors++; $display("FAIL top_byte: got err=%b rdata=%h want 0/000000ca", er, rd); end
    do_req(32'h01000000, 1'b0, 2'd2, 32'd0, rd, er);
    checks++; if (er !== 1'b0 || rd !== 32'h12345678) begin errors++; $display("FAIL err_no_write: got err=%b rdata=%h want 0/12345678", er, rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er;
    do_req(32'h0100000C, 1'b1, 2'd0, 32'h00000011, rd, er);
    do_req(32'h0100000D, 1'b1, 2'd0, 32'h00000022, rd, er);
    do_req(32'h0100000E, 1'b1, 2'd0, 32'h00000033, rd, er);
    do_req(32'h0100000F, 1'b1, 2'd0, 32'h00000044, rd, er);
    do_req(32'h0100000C, 1'b0, 2'd2, 32'd0, rd, er);
    checks++; if (rd !== 32'h44332211) begin errors++; $display("FAIL b2b_lanes: got %h want 44332211", rd); end
    do_req(32'h0100000E, 1'b0, 2'd1, 32'd0, rd, er);
    checks++; if (rd !== 32'h00004433) begin errors++; $display("FAIL b2b_half: got %h want 00004433", rd); end
  endtask

  task automatic test_reset_busy;
    logic [31:0] rd; logic er;
    do_req(32'h01000008, 1'b1, 2'd2, 32'h11223344, rd, er);
    req_addr = 32'h01000008; req_we = 1'b1; req_size = 2'd0; req_wdata = 32'h00000055;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    // Reset lands on the edge where the access would execute.
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL busy_rst_during: got valid=%b ready=%b want 0/0", resp_valid, req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL busy_rst_after: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
    do_req(32'h01000008, 1'b0, 2'd2, 32'd0, rd, er);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL busy_rst_nowrite: got %h want 11223344", rd); end
  endtask

  task automatic test_reset_resp;
    int n;
    @(posedge clk); #1;
    req_addr = 32'h01000000; req_we = 1'b0; req_size = 2'd2;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (resp_rdata !== 32'h12345678) begin errors++; $display("FAIL resp_rst_pre: got %h want 12345678", resp_rdata); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL resp_rst_drop: got valid=%b rdata=%h err=%b want 0/0/0", resp_valid, resp_rdata, resp_err);
    end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL resp_rst_ready: got %b want 1", req_ready); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_we = 1'b0;
    req_size = 2'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    test_reset();
    test_word_rw();
    test_latency();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_reset_busy();
    test_reset_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
